// File: rtl/axi_rd_sequencer.sv
// axi_rd_sequencer
//   Front-end of the AXI read master. Accepts one job (start address, beat
//   count), cuts it into bursts of at most MAX_BURST beats that never cross a
//   4 KB page, and requests them on the master's local port. In parallel it
//   drains the master's read FIFO into a 4-entry output FIFO and presents the
//   beats as a valid/ready stream.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   job_start/addr/beats        job request (ignored while job_busy)
//   job_busy/done/err           job status; done is a 1-cycle pulse, err sticky
//   rd_err                      error flag from the read master
//   lcl_obusy/ostart/oaddr/onum burst request port of the read master
//   lcl_ordy/rden/dv/dout/odone read-FIFO port of the read master
//   o_valid/ready/data/last     output beat stream
//   dbg_state                   current request FSM state (IDLE encodes as 0)
//
// Stream handshake: a beat transfers on a cycle where o_valid and o_ready are
// both 1. Once o_valid is raised, o_valid and o_data hold until that transfer;
// o_valid never depends on o_ready.

module axi_rd_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_start,
  input  logic [ADDR_WIDTH-1:0] job_addr,
  input  logic [LEN_WIDTH-1:0]  job_beats,
  output logic                  job_busy,
  output logic                  job_done,
  output logic                  job_err,
  input  logic                  rd_err,
  input  logic                  lcl_obusy,
  output logic                  lcl_ostart,
  output logic [ADDR_WIDTH-1:0] lcl_oaddr,
  output logic [7:0]            lcl_onum,
  input  logic                  lcl_ordy,
  output logic                  lcl_rden,
  input  logic                  lcl_dv,
  input  logic [DATA_WIDTH-1:0] lcl_dout,
  input  logic                  lcl_odone,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [2:0]            dbg_state
);

  localparam int BPB     = DATA_WIDTH / 8;
  localparam int BPB_LOG = $clog2(BPB);
  // Width wide enough for both the remaining-beat count and the page room.
  localparam int CW      = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ISSUE = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  job_beats_q, job_beats_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;  // beats not yet requested as bursts
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;        // beats read from the master FIFO
  logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;      // beats delivered on o_*
  logic [8:0]            burst_n_q, burst_n_d;      // 9 bits so MAX_BURST=256 fits
  logic                  inflight_q, inflight_d;    // rden last cycle, dv due now
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [4];
  logic [DATA_WIDTH-1:0] fifo_mem_d [4];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            fifo_cnt_q, fifo_cnt_d;

  logic [12:0]           page_room;
  logic [CW-1:0]         n_w;
  logic                  credit_ok;
  logic                  push, pop, last_hs;

  // Burst length: limited by what is left, by MAX_BURST and by the beats
  // remaining before the next 4 KB boundary.
  always_comb begin
    page_room = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> BPB_LOG;
    n_w = CW'(remaining_q);
    if (n_w > CW'(MAX_BURST)) n_w = CW'(MAX_BURST);
    if (n_w > CW'(page_room)) n_w = CW'(page_room);
  end

  assign job_busy   = (state_q != S_IDLE);
  assign job_done   = done_q;
  assign job_err    = err_q;
  assign dbg_state  = state_q;

  assign lcl_ostart = (state_q == S_ISSUE) && !lcl_obusy;
  assign lcl_oaddr  = lcl_ostart ? cur_addr_q : '0;
  assign lcl_onum   = lcl_ostart ? burst_n_q[7:0] : 8'd0;

  // A read issued now lands one cycle later with no way to stall it, so the
  // beat already in flight counts against the free FIFO slots.
  assign credit_ok  = ({1'b0, fifo_cnt_q} + {3'b000, inflight_q}) < 4'd4;
  assign lcl_rden   = job_busy && lcl_ordy && !lcl_odone && credit_ok
                      && (rd_cnt_q < job_beats_q);

  assign o_valid    = (fifo_cnt_q != 3'd0);
  assign o_data     = o_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign o_last     = o_valid && ((out_cnt_q + LEN_WIDTH'(1)) == job_beats_q);

  assign push       = lcl_dv;
  assign pop        = o_valid && o_ready;
  assign last_hs    = pop && o_last;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    job_beats_d = job_beats_q;
    remaining_d = remaining_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    burst_n_d   = burst_n_q;
    inflight_d  = lcl_rden;
    done_d      = 1'b0;
    err_d       = err_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (lcl_rden) rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
    if (push) begin
      fifo_mem_d[wr_ptr_q] = lcl_dout;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 2'd1;
      out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (job_busy && rd_err) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          err_d = 1'b0;
          if (job_beats == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_CALC;
            cur_addr_d  = job_addr & ~ADDR_WIDTH'(BPB - 1);
            job_beats_d = job_beats;
            remaining_d = job_beats;
            rd_cnt_d    = '0;
            out_cnt_d   = '0;
          end
        end
      end
      S_CALC: begin
        burst_n_d = 9'(n_w);
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (!lcl_obusy) begin
          cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(burst_n_q) << BPB_LOG);
          remaining_d = remaining_q - LEN_WIDTH'(burst_n_q);
          state_d     = S_GAP;
        end
      end
      // One idle cycle lets the master's registered obusy catch up.
      S_GAP:   state_d = (remaining_q != '0) ? S_CALC : S_DRAIN;
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase

    // The final beat can only leave after every burst was issued, so ending
    // the job here is safe from whichever state the FSM is in.
    if (last_hs) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      job_beats_q <= '0;
      remaining_q <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      burst_n_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      job_beats_q <= job_beats_d;
      remaining_q <= remaining_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      burst_n_q   <= burst_n_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Read data arriving into a full FIFO means the credit logic is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    lcl_dv |-> (fifo_cnt_q != 3'd4));

endmodule

// File: tb/tb_axi_rd_sequencer.sv
// Bench for axi_rd_sequencer: a read-master model answers burst requests with
// address-derived data; a job-level reference model predicts the burst list,
// the output beat stream and the status pulses.

module tb_axi_rd_sequencer;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 32;
  localparam int MB = 16;

  logic          clk;
  logic          rst_n = 1'b0;
  logic          job_start = 1'b0;
  logic [AW-1:0] job_addr = '0;
  logic [LW-1:0] job_beats = '0;
  logic          job_busy, job_done, job_err;
  logic          rd_err = 1'b0;
  logic          lcl_obusy = 1'b0;
  logic          lcl_ostart;
  logic [AW-1:0] lcl_oaddr;
  logic [7:0]    lcl_onum;
  logic          lcl_ordy = 1'b0;
  logic          lcl_rden;
  logic          lcl_dv = 1'b0;
  logic [DW-1:0] lcl_dout = '0;
  logic          lcl_odone = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [2:0]    dbg_state;

  axi_rd_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_start(job_start), .job_addr(job_addr), .job_beats(job_beats),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .rd_err(rd_err),
    .lcl_obusy(lcl_obusy), .lcl_ostart(lcl_ostart), .lcl_oaddr(lcl_oaddr),
    .lcl_onum(lcl_onum),
    .lcl_ordy(lcl_ordy), .lcl_rden(lcl_rden), .lcl_dv(lcl_dv),
    .lcl_dout(lcl_dout), .lcl_odone(lcl_odone),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_baddr_q[$];
  logic [7:0]    exp_bnum_q[$];
  logic [AW-1:0] obs_baddr_q[$];
  logic [7:0]    obs_bnum_q[$];
  logic [DW-1:0] mfifo_q[$];
  logic          dv_pend = 1'b0;
  logic [DW-1:0] dv_data = '0;
  bit            m_busy = 0, m_done_next = 0, m_err = 0;
  int            m_job_beats = 0, m_rd_total = 0, m_out_total = 0;
  logic [31:0]   salt = 32'h0;
  bit            drv_start = 0;
  logic [AW-1:0] drv_addr = '0;
  logic [LW-1:0] drv_beats = '0;
  bit            hold_ready = 0, hold_busy = 0;
  int            err_rate = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  int            valid_cycles = 0, ostart_count = 0;
  int            n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return a ^ {salt, ~salt};
  endfunction

  // Job-level reference: burst list from the splitting rules, beat stream from
  // the beat addresses.
  task automatic model_start(input logic [AW-1:0] addr, input logic [LW-1:0] beats);
    logic [AW-1:0] a;
    int rem, room, n;
    m_err = 0;
    obs_baddr_q.delete();
    obs_bnum_q.delete();
    if (beats == 0) begin
      m_done_next = 1;
      return;
    end
    salt        = $urandom();
    m_busy      = 1;
    m_job_beats = int'(beats);
    m_rd_total  = 0;
    m_out_total = 0;
    a = addr & ~64'h7;
    for (int i = 0; i < m_job_beats; i++) exp_q.push_back(data_of(a + 64'(i) * 64'd8));
    rem = m_job_beats;
    while (rem > 0) begin
      room = (4096 - int'(a % 64'd4096)) / 8;
      n = rem;
      if (n > MB) n = MB;
      if (n > room) n = room;
      exp_baddr_q.push_back(a);
      exp_bnum_q.push_back(8'(n));
      a   = a + 64'(n) * 64'd8;
      rem = rem - n;
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [AW-1:0] ea;
    logic [7:0]    en;
    logic [DW-1:0] ed;
    @(negedge clk);
    job_start = drv_start;
    job_addr  = drv_addr;
    job_beats = drv_beats;
    lcl_ordy  = (mfifo_q.size() != 0);
    lcl_odone = lcl_ordy && ($urandom_range(0, 7) == 0);
    lcl_obusy = hold_busy || ($urandom_range(0, 3) == 0);
    o_ready   = !hold_ready && ($urandom_range(0, 3) != 0);
    rd_err    = (err_rate > 0) && ($urandom_range(0, 99) < err_rate);
    lcl_dv    = dv_pend;
    lcl_dout  = dv_pend ? dv_data : {$urandom(), $urandom()};
    dv_pend   = 1'b0;
    #1;

    check_eq("job_done", job_done, m_done_next);
    check_eq("job_busy", job_busy, m_busy);
    if (job_done) check_eq("job_err", job_err, m_err);
    m_done_next = 0;
    if (m_busy && rd_err) m_err = 1;
    if (job_start && !m_busy) model_start(job_addr, job_beats);

    if (prev_stall) begin
      check_eq("o_valid_hold", o_valid, 1'b1);
      check_eq("o_data_hold", o_data, prev_data);
    end
    prev_stall = o_valid && !o_ready;
    prev_data  = o_data;
    if (o_valid) valid_cycles++;

    if (lcl_ostart) begin
      ostart_count++;
      check_eq("ostart_while_obusy", lcl_obusy, 1'b0);
      check_eq("burst_expected", exp_baddr_q.size() != 0, 1'b1);
      check_eq("burst_no_4k_cross",
               (lcl_oaddr >> 12) != ((lcl_oaddr + 64'(lcl_onum) * 64'd8 - 64'd1) >> 12), 1'b0);
      if (exp_baddr_q.size() != 0) begin
        ea = exp_baddr_q.pop_front();
        en = exp_bnum_q.pop_front();
        check_eq("burst_addr", lcl_oaddr, ea);
        check_eq("burst_num", lcl_onum, en);
      end
      obs_baddr_q.push_back(lcl_oaddr);
      obs_bnum_q.push_back(lcl_onum);
      for (int j = 0; j < int'(lcl_onum); j++)
        mfifo_q.push_back(data_of(lcl_oaddr + 64'(j) * 64'd8));
    end

    if (lcl_rden) begin
      check_eq("rden_odone", lcl_odone, 1'b0);
      check_eq("rden_ordy", lcl_ordy, 1'b1);
      m_rd_total++;
      check_eq("rden_budget", m_rd_total <= m_job_beats, 1'b1);
      check_eq("rden_credit", (m_rd_total - m_out_total) <= 4, 1'b1);
      if (mfifo_q.size() != 0) begin
        dv_pend = 1'b1;
        dv_data = mfifo_q.pop_front();
      end
    end

    if (o_valid && o_ready) begin
      check_eq("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        ed = exp_q.pop_front();
        check_eq("o_data", o_data, ed);
      end
      m_out_total++;
      check_eq("o_last", o_last, m_out_total == m_job_beats);
      if (m_busy && m_out_total == m_job_beats) begin
        m_busy      = 0;
        m_done_next = 1;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    job_start = 1'b0; lcl_ordy = 1'b0; lcl_odone = 1'b0; lcl_dv = 1'b0;
    lcl_obusy = 1'b0; o_ready = 1'b0; rd_err = 1'b0;
    exp_q.delete(); exp_baddr_q.delete(); exp_bnum_q.delete(); mfifo_q.delete();
    dv_pend = 1'b0; m_busy = 0; m_done_next = 0; m_err = 0;
    drv_start = 0; hold_ready = 0; hold_busy = 0; err_rate = 0; prev_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_job_busy", job_busy, 1'b0);
    check_eq("rst_job_done", job_done, 1'b0);
    check_eq("rst_job_err", job_err, 1'b0);
    check_eq("rst_ostart", lcl_ostart, 1'b0);
    check_eq("rst_oaddr", lcl_oaddr, 64'h0);
    check_eq("rst_onum", lcl_onum, 8'h0);
    check_eq("rst_rden", lcl_rden, 1'b0);
    check_eq("rst_o_valid", o_valid, 1'b0);
    check_eq("rst_o_data", o_data, 64'h0);
    check_eq("rst_o_last", o_last, 1'b0);
    check_eq("rst_state_idle", dbg_state, 3'd0);
  endtask

  task automatic start_job(input logic [AW-1:0] addr, input logic [LW-1:0] beats);
    drv_start = 1; drv_addr = addr; drv_beats = beats;
    step();
    drv_start = 0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((m_busy || m_done_next) && k < bound) begin
      step();
      k++;
    end
    check_eq("job_finished", m_busy || m_done_next, 1'b0);
    check_eq("bursts_left", exp_baddr_q.size(), 0);
    check_eq("beats_left", exp_q.size(), 0);
    if (m_busy || m_done_next) apply_reset();
  endtask

  task automatic run_job(input logic [AW-1:0] addr, input logic [LW-1:0] beats);
    start_job(addr, beats);
    wait_idle(3000);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int vc0, oc0, n_os;
    logic [AW-1:0] ra;
    int rb;

    apply_reset();
    repeat (2) step();

    // basic split at a page start: 16 + 16 + 8
    run_job(64'h1000, 40);
    check_eq("t1_nbursts", obs_baddr_q.size(), 3);
    if (obs_baddr_q.size() == 3) begin
      check_eq("t1_b0_addr", obs_baddr_q[0], 64'h1000);
      check_eq("t1_b0_num", obs_bnum_q[0], 8'd16);
      check_eq("t1_b1_addr", obs_baddr_q[1], 64'h1080);
      check_eq("t1_b1_num", obs_bnum_q[1], 8'd16);
      check_eq("t1_b2_addr", obs_baddr_q[2], 64'h1100);
      check_eq("t1_b2_num", obs_bnum_q[2], 8'd8);
    end

    // 4 KB boundary: first burst stops at the page end
    run_job(64'h0FC0, 20);
    check_eq("t2_nbursts", obs_baddr_q.size(), 2);
    if (obs_baddr_q.size() == 2) begin
      check_eq("t2_b0_addr", obs_baddr_q[0], 64'h0FC0);
      check_eq("t2_b0_num", obs_bnum_q[0], 8'd8);
      check_eq("t2_b1_addr", obs_baddr_q[1], 64'h1000);
      check_eq("t2_b1_num", obs_bnum_q[1], 8'd12);
    end

    // zero-length job
    vc0 = valid_cycles;
    oc0 = ostart_count;
    run_job(64'h4000, 0);
    check_eq("t3_no_ostart", ostart_count - oc0, 0);
    check_eq("t3_no_valid", valid_cycles - vc0, 0);

    // output stalled for 20 cycles
    start_job(64'h3000, 40);
    repeat (5) step();
    hold_ready = 1;
    repeat (20) step();
    check_eq("t4_buffered", m_rd_total - m_out_total, 4);
    check_eq("t4_valid_held", o_valid, 1'b1);
    hold_ready = 0;
    wait_idle(3000);

    // obusy held for 10 cycles; a second start during busy must be ignored
    hold_busy = 1;
    start_job(64'h2000, 20);
    n_os = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        drv_start = 1; drv_addr = 64'h9000; drv_beats = 5;
      end
      step();
      drv_start = 0;
      if (lcl_ostart) n_os++;
    end
    check_eq("t5_ostart_deferred", n_os, 0);
    hold_busy = 0;
    wait_idle(3000);

    // rd_err sets job_err, next clean job clears it
    err_rate = 30;
    run_job(64'h7008, 30);
    err_rate = 0;
    run_job(64'h7800, 10);

    // reset in the middle of a job, then a normal job
    start_job(64'h5000, 64);
    repeat (8) step();
    apply_reset();
    repeat (2) step();
    run_job(64'h5000, 64);

    // randomized jobs: arbitrary, near-page-end and top-of-address-space starts
    for (int j = 0; j < 25; j++) begin
      case ($urandom_range(0, 3))
        0:       ra = {$urandom(), $urandom()};
        1:       ra = {$urandom(), 20'($urandom()), 4'hF, 8'($urandom())};
        2:       ra = 64'hFFFF_FFFF_FFFF_F000 | 64'($urandom_range(0, 4095));
        default: ra = 64'($urandom_range(0, 65535));
      endcase
      rb = (j % 8 == 7) ? 0 : int'($urandom_range(1, 80));
      err_rate = ($urandom_range(0, 2) == 0) ? 3 : 0;
      run_job(ra, LW'(rb));
      if ($urandom_range(0, 1) == 0) step();
    end
    err_rate = 0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
